// File: rtl/dht11_poll_scheduler.sv
// DHT11 read scheduler: paces sensor transactions, retries failed reads a bounded number
// of times, and holds the last good humidity/temperature with stale/fault indications.
module dht11_poll_scheduler #(
   parameter int unsigned POWERUP_MS     = 1000,
   parameter int unsigned POLL_PERIOD_MS = 2000,
   parameter int unsigned MIN_GAP_MS     = 1000,
   parameter int unsigned RETRY_DELAY_MS = 1100,
   parameter int unsigned RESP_WINDOW_MS = 30,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iTickUs,
   input  logic       iEnable,
   input  logic       iTrigger,
   input  logic       iDone,
   input  logic       iFail,
   input  logic [7:0] iHumInt,
   input  logic [7:0] iTempInt,
   output logic       oStart,
   output logic       oBusy,
   output logic [7:0] oHum,
   output logic [7:0] oTemp,
   output logic       oSampleValid,
   output logic       oStale,
   output logic       oFault,
   output logic [7:0] oErrCnt
);
   localparam logic [15:0] PowerupMs    = 16'(POWERUP_MS);
   localparam logic [15:0] PollPeriodMs = 16'(POLL_PERIOD_MS);
   localparam logic [15:0] MinGapMs     = 16'(MIN_GAP_MS);
   localparam logic [15:0] RetryDelayMs = 16'(RETRY_DELAY_MS);
   localparam logic [15:0] RespWindowMs = 16'(RESP_WINDOW_MS);
   localparam logic [7:0]  MaxRetry     = 8'(MAX_RETRY);

   typedef enum logic [1:0] {IDLE, WAIT_GAP, ISSUE, BUSY} stateT;

   stateT       state;
   logic [9:0]  usCnt;
   logic [15:0] msCnt;
   logic [15:0] targetMs;
   logic        targetIsPowerup;
   logic        issued;
   logic        pending;
   logic [7:0]  retryCnt;
   logic        gapReached;
   logic        watchdogHit;

   // A pending manual trigger may shorten any gap except the power-up settle time.
   assign gapReached  = (msCnt >= targetMs) ||
                        (pending && !targetIsPowerup && (msCnt >= MinGapMs));
   assign watchdogHit = (msCnt >= RespWindowMs);

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state           <= IDLE;
         usCnt           <= '0;
         msCnt           <= '0;
         targetMs        <= PowerupMs;
         targetIsPowerup <= 1'b1;
         issued          <= 1'b0;
         pending         <= 1'b0;
         retryCnt        <= '0;
         oStart          <= 1'b0;
         oBusy           <= 1'b0;
         oHum            <= '0;
         oTemp           <= '0;
         oSampleValid    <= 1'b0;
         oStale          <= 1'b1;
         oFault          <= 1'b0;
         oErrCnt         <= '0;
      end else begin
         oStart       <= 1'b0;
         oSampleValid <= 1'b0;

         if (iTickUs) begin
            if (usCnt == 10'd999) begin
               usCnt <= '0;
               if (msCnt != 16'hFFFF) msCnt <= msCnt + 16'd1;
            end else begin
               usCnt <= usCnt + 10'd1;
            end
         end

         if (iTrigger && state != ISSUE) pending <= 1'b1;

         // Every transition below clears the time base, so gaps are measured from entry.
         case (state)
            IDLE: begin
               usCnt <= '0;
               msCnt <= '0;
               if (iEnable) begin
                  state           <= WAIT_GAP;
                  targetMs        <= issued ? PollPeriodMs : PowerupMs;
                  targetIsPowerup <= !issued;
               end
            end
            WAIT_GAP: begin
               if (!iEnable) begin
                  state <= IDLE;
                  usCnt <= '0;
                  msCnt <= '0;
               end else if (gapReached) begin
                  state  <= ISSUE;
                  oStart <= 1'b1;
                  usCnt  <= '0;
                  msCnt  <= '0;
               end
            end
            ISSUE: begin
               state   <= BUSY;
               oBusy   <= 1'b1;
               pending <= 1'b0;
               issued  <= 1'b1;
               usCnt   <= '0;
               msCnt   <= '0;
            end
            BUSY: begin
               if (iDone || iFail || watchdogHit) begin
                  state           <= iEnable ? WAIT_GAP : IDLE;
                  oBusy           <= 1'b0;
                  targetIsPowerup <= 1'b0;
                  usCnt           <= '0;
                  msCnt           <= '0;
                  if (iDone) begin
                     oHum         <= iHumInt;
                     oTemp        <= iTempInt;
                     oSampleValid <= 1'b1;
                     oStale       <= 1'b0;
                     oFault       <= 1'b0;
                     retryCnt     <= '0;
                     targetMs     <= PollPeriodMs;
                  end else begin
                     if (oErrCnt != 8'hFF) oErrCnt <= oErrCnt + 8'd1;
                     if (retryCnt < MaxRetry) begin
                        retryCnt <= retryCnt + 8'd1;
                        targetMs <= RetryDelayMs;
                     end else begin
                        oFault   <= 1'b1;
                        oStale   <= 1'b1;
                        retryCnt <= '0;
                        targetMs <= PollPeriodMs;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// Self-checking bench for dht11_poll_scheduler: randomized tick spacing and sensor
// responses, compared against a transaction-level model of the scheduling rules.
module tb_dht11_poll_scheduler;
   localparam int POWERUP = 3, POLL = 5, MINGAP = 2, RETRY = 4, RESP = 2, MAXR = 2;
   localparam int K_DONE = 0, K_FAIL = 1, K_BOTH = 2, K_TIMEOUT = 3, K_DONE_WD = 4;

   logic       iClk;
   logic       iRst, iTickUs, iEnable, iTrigger, iDone, iFail;
   logic [7:0] iHumInt, iTempInt;
   logic       oStart, oBusy, oSampleValid, oStale, oFault;
   logic [7:0] oHum, oTemp, oErrCnt;
   logic       iEnable2, iFail2;
   logic       oStart2, oBusy2, oSampleValid2, oStale2, oFault2;
   logic [7:0] oHum2, oTemp2, oErrCnt2;

   int checks = 0;
   int errors = 0;
   int tickCount = 0;
   int tickPrev = 0;
   logic [1:0] tickHist = 2'b00;
   int refGap, refBusy;

   // Model of the scheduler's observable state
   logic [7:0] mHum, mTemp, mErr;
   bit mStale, mFault, mPending, mIssued, mPowerup;
   int mRetry, mTarget;

   dht11_poll_scheduler #(.POWERUP_MS(POWERUP), .POLL_PERIOD_MS(POLL), .MIN_GAP_MS(MINGAP),
      .RETRY_DELAY_MS(RETRY), .RESP_WINDOW_MS(RESP), .MAX_RETRY(MAXR)) dut (
      .iClk(iClk), .iRst(iRst), .iTickUs(iTickUs), .iEnable(iEnable), .iTrigger(iTrigger),
      .iDone(iDone), .iFail(iFail), .iHumInt(iHumInt), .iTempInt(iTempInt),
      .oStart(oStart), .oBusy(oBusy), .oHum(oHum), .oTemp(oTemp),
      .oSampleValid(oSampleValid), .oStale(oStale), .oFault(oFault), .oErrCnt(oErrCnt));

   // Zero-gap instance so hundreds of failures fit in a short run
   dht11_poll_scheduler #(.POWERUP_MS(0), .POLL_PERIOD_MS(0), .MIN_GAP_MS(0),
      .RETRY_DELAY_MS(0), .RESP_WINDOW_MS(2), .MAX_RETRY(1)) dutSat (
      .iClk(iClk), .iRst(iRst), .iTickUs(1'b0), .iEnable(iEnable2), .iTrigger(1'b0),
      .iDone(1'b0), .iFail(iFail2), .iHumInt(8'h00), .iTempInt(8'h00),
      .oStart(oStart2), .oBusy(oBusy2), .oHum(oHum2), .oTemp(oTemp2),
      .oSampleValid(oSampleValid2), .oStale(oStale2), .oFault(oFault2), .oErrCnt(oErrCnt2));

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   initial begin
      iTickUs = 1'b0;
      forever begin
         @(negedge iClk);
         iTickUs = ($urandom_range(15) != 0);
      end
   end

   always @(posedge iClk) begin
      tickHist  <= {tickHist[0], iTickUs};
      tickPrev  <= tickCount;
      tickCount <= tickCount + (iTickUs ? 1 : 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mHum = 0; mTemp = 0; mErr = 0; mStale = 1; mFault = 0; mPending = 0;
      mIssued = 0; mRetry = 0; mTarget = POWERUP; mPowerup = 1;
   endtask

   task automatic modelEnable();
      mTarget  = mIssued ? POLL : POWERUP;
      mPowerup = !mIssued;
   endtask

   task automatic modelDone(input logic [7:0] h, input logic [7:0] t);
      mHum = h; mTemp = t; mStale = 0; mFault = 0; mRetry = 0;
      mTarget = POLL; mPowerup = 0;
   endtask

   task automatic modelFail();
      mErr = (mErr == 8'd255) ? 8'd255 : mErr + 8'd1;
      mPowerup = 0;
      if (mRetry < MAXR) begin
         mRetry++;
         mTarget = RETRY;
      end else begin
         mFault = 1; mStale = 1; mRetry = 0; mTarget = POLL;
      end
   endtask

   task automatic checkRst(input string tag);
      check({tag, "_start"}, oStart, 0);
      check({tag, "_busy"}, oBusy, 0);
      check({tag, "_hum"}, oHum, 0);
      check({tag, "_temp"}, oTemp, 0);
      check({tag, "_valid"}, oSampleValid, 0);
      check({tag, "_stale"}, oStale, 1);
      check({tag, "_fault"}, oFault, 0);
      check({tag, "_errcnt"}, oErrCnt, 0);
   endtask

   // Waits for oStart and checks the tick distance from the gap reference point.
   task automatic doStart(input string tag, input int trigAt);
      int expMs, el;
      bit ok, fired, lt;
      if (trigAt >= 0) mPending = 1;
      expMs = (mPending && !mPowerup && MINGAP < mTarget) ? MINGAP : mTarget;
      ok = 0; fired = 0; el = 0; lt = 0;
      for (int c = 0; c < 9000 && !ok; c++) begin
         @(negedge iClk);
         iTrigger = 1'b0;
         if (oStart) begin
            ok = 1;
            el = tickPrev - refGap;
            lt = tickHist[1];
         end else if (trigAt >= 0 && !fired && (tickCount - refGap) >= trigAt) begin
            iTrigger = 1'b1;
            fired = 1;
         end
      end
      iTrigger = 1'b0;
      check({tag, "_found"}, ok, 1);
      check({tag, "_gap_ticks"}, el, expMs * 1000);
      check({tag, "_gap_edge"}, lt, 1);
      check({tag, "_issue_busy"}, oBusy, 0);
      mPending = 0;
      mIssued = 1;
      @(negedge iClk);
      check({tag, "_start_width"}, oStart, 0);
      check({tag, "_busy"}, oBusy, 1);
      refBusy = tickCount;
   endtask

   task automatic respond(input string tag, input int kind, input bit trigBusy,
                          input logic [7:0] h, input logic [7:0] t);
      bit ok, good;
      int d;
      good = (kind == K_DONE || kind == K_BOTH || kind == K_DONE_WD);
      iHumInt = h;
      iTempInt = t;
      if (trigBusy) begin
         iTrigger = 1'b1;
         @(negedge iClk);
         iTrigger = 1'b0;
         mPending = 1;
      end
      if (kind == K_TIMEOUT) begin
         ok = 0;
         for (int c = 0; c < 4000 && !ok; c++) begin
            @(negedge iClk);
            if (!oBusy) ok = 1;
         end
         check({tag, "_wd_found"}, ok, 1);
         check({tag, "_wd_ticks"}, tickPrev - refBusy, RESP * 1000);
         check({tag, "_wd_edge"}, tickHist[1], 1);
      end else if (kind == K_DONE_WD) begin
         ok = 0;
         for (int c = 0; c < 4000 && !ok; c++) begin
            if ((tickCount - refBusy) >= RESP * 1000) ok = 1;
            else @(negedge iClk);
         end
         check({tag, "_wd_align"}, tickCount - refBusy, RESP * 1000);
         check({tag, "_wd_still_busy"}, oBusy, 1);
         iDone = 1'b1;
         @(negedge iClk);
         iDone = 1'b0;
      end else begin
         d = $urandom_range(1, 20);
         repeat (d) @(negedge iClk);
         iDone = (kind != K_FAIL);
         iFail = (kind != K_DONE);
         @(negedge iClk);
         iDone = 1'b0;
         iFail = 1'b0;
      end
      refGap = tickCount;
      if (good) modelDone(h, t);
      else modelFail();
      check({tag, "_hum"}, oHum, mHum);
      check({tag, "_temp"}, oTemp, mTemp);
      check({tag, "_valid"}, oSampleValid, good);
      check({tag, "_stale"}, oStale, mStale);
      check({tag, "_fault"}, oFault, mFault);
      check({tag, "_errcnt"}, oErrCnt, mErr);
      check({tag, "_busy_fall"}, oBusy, 0);
      @(negedge iClk);
      check({tag, "_valid_width"}, oSampleValid, 0);
   endtask

   initial begin
      bit seen, ok;
      int kind;
      iRst = 1'b1; iEnable = 1'b0; iTrigger = 1'b0; iDone = 1'b0; iFail = 1'b0;
      iHumInt = 8'h00; iTempInt = 8'h00; iEnable2 = 1'b0; iFail2 = 1'b0;
      modelReset();
      repeat (3) @(negedge iClk);
      checkRst("reset");
      iRst = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge iClk);
         if (oStart) seen = 1;
      end
      check("idle_no_start", seen, 0);

      iEnable = 1'b1;
      @(negedge iClk);
      refGap = tickCount;
      modelEnable();
      doStart("powerup", -1);
      respond("first_done", K_DONE, 0, 8'h37, 8'h19);

      doStart("poll", -1);
      respond("fail1", K_FAIL, 0, 8'($urandom), 8'($urandom));
      doStart("retry1", -1);
      respond("timeout2", K_TIMEOUT, 0, 8'($urandom), 8'($urandom));
      doStart("retry2", -1);
      respond("fail3_fault", K_FAIL, 0, 8'($urandom), 8'($urandom));
      check("fault_errcnt3", oErrCnt, 3);
      doStart("after_fault", -1);
      respond("fault_clear", K_DONE, 0, 8'($urandom), 8'($urandom));

      doStart("trig_in_gap", 100);
      respond("trig_busy_done", K_DONE, 1, 8'($urandom), 8'($urandom));
      doStart("trig_from_busy", -1);
      respond("done_and_fail", K_BOTH, 0, 8'($urandom), 8'($urandom));
      doStart("after_both", -1);
      respond("done_at_wd", K_DONE_WD, 0, 8'($urandom), 8'($urandom));

      for (int r = 0; r < 2; r++) begin
         doStart("rnd_start", ($urandom_range(1) == 1) ? int'($urandom_range(1500)) : -1);
         kind = int'($urandom_range(2));
         respond("rnd_resp", kind, bit'($urandom_range(1)), 8'($urandom), 8'($urandom));
      end

      doStart("pre_disable", -1);
      iEnable = 1'b0;
      respond("disable_done", K_DONE, 0, 8'($urandom), 8'($urandom));
      seen = 0;
      for (int c = 0; c < 7000 && (tickCount - refGap) < 5500; c++) begin
         @(negedge iClk);
         if (oStart) seen = 1;
      end
      check("disabled_no_start", seen, 0);
      iEnable = 1'b1;
      @(negedge iClk);
      refGap = tickCount;
      modelEnable();
      doStart("reenable", -1);

      repeat (3) @(negedge iClk);
      iRst = 1'b1;
      @(negedge iClk);
      checkRst("mid_busy_reset");
      iRst = 1'b0;
      modelReset();
      @(negedge iClk);
      refGap = tickCount;
      modelEnable();
      doStart("post_reset", -1);
      respond("post_reset_done", K_DONE, 0, 8'($urandom), 8'($urandom));

      iEnable2 = 1'b1;
      for (int i = 1; i <= 260; i++) begin
         ok = 0;
         for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge iClk);
            if (oStart2) ok = 1;
         end
         if (!ok) begin
            check("sat_start_found", ok, 1);
            break;
         end
         @(negedge iClk);
         iFail2 = 1'b1;
         @(negedge iClk);
         iFail2 = 1'b0;
         if (i == 1 || i == 254 || i == 255 || i == 256 || i == 260)
            check("sat_errcnt", oErrCnt2, (i > 255) ? 255 : i);
      end
      check("sat_fault", oFault2, 1);
      check("sat_stale", oStale2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dht11_poll_scheduler.md
# dht11_poll_scheduler

Sequences periodic reads of the DHT11 sensor interface. It spaces transactions to respect the sensor's minimum inter-read gap and retries failed reads a bounded number of times. It latches the last good humidity/temperature pair and flags stale data or a persistent fault. It sits between the system control logic and the DHT11 controller and owns that controller's start request.

## Interface
- `POWERUP_MS`, 1000: wait after reset and first enable before the first read.
- `POLL_PERIOD_MS`, 2000: gap between the end of a transaction and the next scheduled read.
- `MIN_GAP_MS`, 1000: minimum gap before a manual trigger may start a read.
- `RETRY_DELAY_MS`, 1100: gap before retrying a failed read.
- `RESP_WINDOW_MS`, 30: watchdog on a started transaction.
- `MAX_RETRY`, 3: retries after the first failure before fault is declared.
- All `_MS` parameters are ≤ 65535.
- `iClk` in 1: system clock. One clock; reset is synchronous and active-high.
- `iRst` in 1: synchronous active-high reset.
- `iTickUs` in 1: 1-cycle pulse per microsecond.
- `iEnable` in 1: level; allows scheduling.
- `iTrigger` in 1: 1-cycle request for an early read.
- `iDone` in 1: 1-cycle pulse; sensor transaction ended with a good checksum.
- `iFail` in 1: 1-cycle pulse; sensor transaction timed out or had a checksum error.
- `iHumInt` in 8: humidity from the controller, valid in the cycle `iDone` is high.
- `iTempInt` in 8: temperature from the controller, valid in the cycle `iDone` is high.
- `oStart` out 1: 1-cycle start pulse to the controller.
- `oBusy` out 1: high while a transaction is outstanding.
- `oHum` out 8: last good humidity.
- `oTemp` out 8: last good temperature.
- `oSampleValid` out 1: 1-cycle pulse when `oHum`/`oTemp` update.
- `oStale` out 1: no good sample since reset or since the last fault.
- `oFault` out 1: retries exhausted; cleared by the next good sample.
- `oErrCnt` out 8: saturating count of failed attempts.

## Operation
- Time base:
  - A 10-bit µs counter wraps at 999 and emits an internal ms tick.
  - A 16-bit ms counter counts those ticks.
  - Both counters clear on every state entry, so a gap of N ms is exactly N×1000 `iTickUs` pulses after entry.
- States: IDLE, WAIT_GAP, ISSUE, BUSY.
- IDLE:
  - `iEnable`=1 moves to WAIT_GAP.
  - The target is `POWERUP_MS` if no read has been issued since reset, otherwise `POLL_PERIOD_MS`.
- WAIT_GAP:
  - Moves to ISSUE when ms count ≥ target.
  - Also moves to ISSUE when the trigger-pending flag is set and ms count ≥ `MIN_GAP_MS`; this applies only if the current target is not `POWERUP_MS`.
  - `iEnable`=0 moves to IDLE. The pending flag is retained.
- ISSUE:
  - `oStart`=1 for this single cycle, then BUSY.
  - The pending flag clears here.
- BUSY: `oBusy`=1. Exits are evaluated in priority order:
  - `iDone`:
    - Latch `iHumInt`/`iTempInt` into `oHum`/`oTemp`.
    - Retry count ← 0; `oFault` ← 0; `oStale` ← 0.
    - Go to WAIT_GAP with target `POLL_PERIOD_MS`.
  - `iFail`, or ms count ≥ `RESP_WINDOW_MS`:
    - `oErrCnt` increments, saturating at 255.
    - If retry count < `MAX_RETRY`: retry count +1, WAIT_GAP with target `RETRY_DELAY_MS`.
    - Otherwise: `oFault` ← 1, `oStale` ← 1, retry count ← 0, WAIT_GAP with target `POLL_PERIOD_MS`.
  - `iEnable`=0 during BUSY does not abort. The transaction completes normally, then the block goes to IDLE instead of WAIT_GAP. Outputs still update.
- Simultaneous events:
  - `iDone` and `iFail` together: `iDone` wins.
  - `iDone` and a watchdog expiry together: `iDone` wins.
- `iTrigger` sets the pending flag in any state except ISSUE. A trigger in BUSY is serviced after `MIN_GAP_MS` of the following WAIT_GAP.
- `iDone`/`iFail` outside BUSY are ignored.

## Timing
- Reset values:
  - state IDLE;
  - `oStart`=0, `oBusy`=0, `oHum`=0, `oTemp`=0, `oSampleValid`=0, `oStale`=1, `oFault`=0, `oErrCnt`=0;
  - retry count, pending flag and counters all 0.
- Reset mid-BUSY returns the block to IDLE immediately. The next read again waits `POWERUP_MS`.
- Enable to first `oStart`:
  - 1 cycle to enter WAIT_GAP;
  - + `POWERUP_MS`×1000 ticks;
  - + 1 cycle for ISSUE.
- `oStart` asserts in the cycle after the gap condition is met and is never high for 2 consecutive cycles.
- `oHum`/`oTemp`/`oSampleValid`/`oStale`/`oFault` update on the clock edge after the `iDone` cycle. `oSampleValid` is high for exactly that one cycle.
- The watchdog fires when the ms count reaches `RESP_WINDOW_MS` in BUSY. It is evaluated on the same edge as `iDone`/`iFail`.
- `oBusy` rises on ISSUE→BUSY and falls on the BUSY exit edge.

## Test plan
Benches use `POWERUP_MS`=3, `POLL_PERIOD_MS`=5, `MIN_GAP_MS`=2, `RETRY_DELAY_MS`=4, `RESP_WINDOW_MS`=2, `MAX_RETRY`=2.
- Power-up:
  - Stimulus: reset, then `iEnable`=1.
  - Response: first `oStart` exactly 3000 ticks after entering WAIT_GAP.
  - Then: `iDone` with hum=0x37, temp=0x19 gives `oHum`=0x37, `oTemp`=0x19, `oSampleValid` pulse, `oStale`=0.
  - Then: next `oStart` 5000 ticks later.
- Retry to fault:
  - Stimulus: answer 3 consecutive starts with `iFail`.
  - Response: retries spaced 4000 ticks; after the third failure `oFault`=1, `oStale`=1, `oErrCnt`=3, next start after 5000 ticks.
  - Then: a subsequent `iDone` clears `oFault` and `oStale`.
- Watchdog:
  - Stimulus: no response after `oStart`.
  - Response: BUSY exits after 2000 ticks, `oErrCnt` increments, retry scheduled.
- Trigger:
  - Stimulus: `iTrigger` 100 ticks into a `POLL_PERIOD_MS` gap.
  - Response: `oStart` at 2000 ticks.
  - Stimulus: `iTrigger` during BUSY.
  - Response: serviced 2000 ticks after completion.
- Disable during BUSY, simultaneous events:
  - Stimulus: drop `iEnable` mid-BUSY, then `iDone`.
  - Response: data latched, state goes to IDLE, no further `oStart`.
  - Stimulus: `iDone` and `iFail` in the same cycle.
  - Response: treated as success, `oErrCnt` unchanged.
- Saturation, reset:
  - Stimulus: force 260 failures.
  - Response: `oErrCnt`=255.
  - Stimulus: assert `iRst` mid-BUSY.
  - Response: all outputs return to reset values on the next edge.
